// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time tester controller.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    GO     = 3'd2,
    RESULT = 3'd3,
    ERROR  = 3'd4
  } state_e;

  localparam int          MAX_MS       = 9999;
  localparam int          MIN_DELAY_MS = 1000;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;
  // Taps 16,14,13,11 expressed as zero-based bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  // One Fibonacci step: shift left, feed back XOR of the tapped bits.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICKS_PER_MS clocks, restartable.
module ms_tick_gen #(
  parameter int TICKS_PER_MS = 10000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS_PER_MS - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: wrap after the last tick cycle, restart from zero on clear.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + W'(1);
    if (clear) cnt_d = '0;
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game controller: random arm delay, GO stimulus, ms measurement,
// best-score tracking and display value / error selection.
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int TICKS_PER_MS = 10000,
  parameter int LOCKOUT_MS   = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn,
  output logic [13:0] value,
  output logic        show_error,
  output logic        go_led
);

  localparam int LW = (LOCKOUT_MS > 0) ? $clog2(LOCKOUT_MS + 1) : 1;

  logic          sync1_q, sync2_q, prev_q, press_q;
  logic [LW-1:0] lock_q;
  logic [15:0]   lfsr_q;
  state_e        state_q;
  logic [11:0]   delay_q;
  logic [13:0]   count_q, result_q, best_q;
  logic [13:0]   value_q;
  logic          show_error_q, go_led_q;

  logic          tick, accept, enter_wait, enter_go, sat, better;
  logic [11:0]   new_delay;
  logic [13:0]   go_res;

  // A press is a synchronized rising edge seen while the debounce lockout is idle.
  assign accept     = sync2_q & ~prev_q & (lock_q == '0);
  assign enter_wait = (state_q == IDLE) && press_q;
  assign enter_go   = (state_q == WAIT) && !press_q && tick && (delay_q == 12'd1);
  assign sat        = (state_q == GO) && tick && (count_q == 14'(MAX_MS - 1));
  assign go_res     = sat ? 14'(MAX_MS) : count_q;
  assign better     = (go_res != '0) && ((best_q == '0) || (go_res < best_q));
  assign new_delay  = 12'(MIN_DELAY_MS) + 12'(lfsr_q[10:0]);

  ms_tick_gen #(.TICKS_PER_MS(TICKS_PER_MS)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (enter_wait | enter_go),
    .tick    (tick)
  );

  // Button synchronizer, edge register, debounce lockout and free-running LFSR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      lock_q  <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= accept;
      if (accept)                   lock_q <= LW'(LOCKOUT_MS);
      else if (tick && lock_q != '0) lock_q <= lock_q - LW'(1);
      lfsr_q  <= lfsr_next(lfsr_q);
    end
  end

  // Game FSM with its delay, reaction-count, result and best-score registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      delay_q  <= '0;
      count_q  <= '0;
      result_q <= '0;
      best_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (press_q) begin
          state_q <= WAIT;
          delay_q <= new_delay;
        end
        // An early press beats the delay expiring on the same cycle.
        WAIT: if (press_q) begin
          state_q <= ERROR;
        end else if (tick) begin
          delay_q <= delay_q - 12'd1;
          if (enter_go) begin
            state_q <= GO;
            count_q <= '0;
          end
        end
        // Saturation on the press cycle still reports the saturated value.
        GO: if (press_q || sat) begin
          state_q  <= RESULT;
          result_q <= go_res;
          if (better) best_q <= go_res;
        end else if (tick) begin
          count_q <= count_q + 14'd1;
        end
        RESULT, ERROR: if (press_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Registered display and LED outputs decoded from the current state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q      <= '0;
      show_error_q <= 1'b0;
      go_led_q     <= 1'b0;
    end else begin
      go_led_q     <= (state_q == GO);
      show_error_q <= (state_q == ERROR);
      case (state_q)
        IDLE:    value_q <= best_q;
        RESULT:  value_q <= result_q;
        default: value_q <= '0;
      endcase
    end
  end

  assign value      = value_q;
  assign show_error = show_error_q;
  assign go_led     = go_led_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Randomized scenario bench for reaction_timer_ctrl with a spec-level model.
module tb_reaction_timer_ctrl;

  localparam int T  = 4;
  localparam int LK = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        btn = 1'b0;
  logic [13:0] value;
  logic        show_error, go_led;

  int          checks = 0;
  int          errors = 0;
  int          best_m = 0;
  logic [15:0] m_lfsr;

  reaction_timer_ctrl #(.TICKS_PER_MS(T), .LOCKOUT_MS(LK)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn        (btn),
    .value      (value),
    .show_error (show_error),
    .go_led     (go_led)
  );

  always #5 clk = ~clk;

  // Pseudo-random source: 16-bit Fibonacci shift register, taps 16,14,13,11.
  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always @(posedge clk or negedge reset_n)
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= lstep(m_lfsr);

  // Best-score rule: a non-zero result replaces an empty or worse best.
  function automatic int best_rule(input int best, input int res);
    if (res != 0 && (best == 0 || res < best)) return res;
    return best;
  endfunction

  // Clean press: btn high for two cycles; ends 5 edges after the rise.
  task automatic tap();
    btn = 1'b1;
    repeat (2) @(negedge clk);
    btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Idle gap long enough for the lockout to expire.
  task automatic gap();
    repeat (12 + $urandom_range(0, 7)) @(negedge clk);
  endtask

  // Start a round from IDLE choosing a moment with a short delay; ends 5 edges
  // after the first rise, returning the delay the press cycle should load.
  task automatic arm(input logic bounce, output int d);
    logic [15:0] fut;
    logic [4:0]  pat;
    pat = bounce ? 5'b10101 : 5'b00111;
    d = 0;
    for (int n = 0; n < 5000; n++) begin
      fut = lstep(lstep(lstep(m_lfsr)));
      if (fut[10:0] < 11'd16) break;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      btn = pat[i];
      if (i == 3) d = 1000 + int'(m_lfsr[10:0]);
      @(negedge clk);
    end
    btn = 1'b0;
  endtask

  task automatic wait_go(input int d, output int n);
    n = 0;
    while (go_led !== 1'b1 && n < d * T + 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    btn     = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (value !== 14'd0 || show_error !== 1'b0 || go_led !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got value=%0d err=%b go=%b want 0 0 0", value, show_error, go_led);
    end
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (value !== 14'd0 || show_error !== 1'b0 || go_led !== 1'b0) begin
      errors++;
      $display("FAIL idle_outputs got value=%0d err=%b go=%b want 0 0 0", value, show_error, go_led);
    end
  endtask

  task automatic test_timeout();
    int d, n, n2;
    gap();
    arm(1'b0, d);
    checks++;
    if (value !== 14'd0 || go_led !== 1'b0) begin
      errors++;
      $display("FAIL wait_outputs got value=%0d go=%b want 0 0", value, go_led);
    end
    wait_go(d, n);
    checks++;
    if (n != d * T) begin
      errors++;
      $display("FAIL go_delay got %0d cycles want %0d", n, d * T);
    end
    n2 = 0;
    while (go_led === 1'b1 && n2 < 40100) begin
      @(negedge clk);
      n2++;
    end
    checks++;
    if (n2 != 9999 * T) begin
      errors++;
      $display("FAIL timeout_len got %0d cycles want %0d", n2, 9999 * T);
    end
    checks++;
    if (value !== 14'd9999) begin
      errors++;
      $display("FAIL timeout_value got %0d want 9999", value);
    end
    best_m = best_rule(best_m, 9999);
    gap();
    tap();
    checks++;
    if (value !== 14'(best_m)) begin
      errors++;
      $display("FAIL idle_best_after_timeout got %0d want %0d", value, best_m);
    end
  endtask

  task automatic test_rounds();
    int tgts[3] = '{150, 200, 90};
    int d, n, w, exp;
    foreach (tgts[k]) begin
      gap();
      arm(1'b0, d);
      wait_go(d, n);
      checks++;
      if (n != d * T) begin
        errors++;
        $display("FAIL round_go_delay got %0d want %0d", n, d * T);
      end
      w = tgts[k] * T - 4 + $urandom_range(0, 3);
      repeat (w) @(negedge clk);
      tap();
      exp = (w + 4) / T;
      checks++;
      if (value !== 14'(exp) || go_led !== 1'b0 || show_error !== 1'b0) begin
        errors++;
        $display("FAIL round_result got value=%0d go=%b want %0d go=0", value, go_led, exp);
      end
      best_m = best_rule(best_m, exp);
      gap();
      tap();
      checks++;
      if (value !== 14'(best_m)) begin
        errors++;
        $display("FAIL round_best got %0d want %0d", value, best_m);
      end
    end
  endtask

  // Press whose pulse lands on the GO entry cycle: a valid 0 ms result.
  task automatic test_zero_result();
    int d;
    gap();
    arm(1'b0, d);
    repeat (d * T - 4) @(negedge clk);
    tap();
    checks++;
    if (value !== 14'd0 || go_led !== 1'b0 || show_error !== 1'b0) begin
      errors++;
      $display("FAIL zero_result got value=%0d go=%b err=%b want 0 0 0", value, go_led, show_error);
    end
    gap();
    tap();
    checks++;
    if (value !== 14'(best_m)) begin
      errors++;
      $display("FAIL zero_keeps_best got %0d want %0d", value, best_m);
    end
  endtask

  task automatic test_false_start();
    int d;
    logic seen_go;
    gap();
    arm(1'b0, d);
    repeat ($urandom_range(4, 400)) @(negedge clk);
    tap();
    checks++;
    if (show_error !== 1'b1 || go_led !== 1'b0 || value !== 14'd0) begin
      errors++;
      $display("FAIL false_start got err=%b go=%b value=%0d want 1 0 0", show_error, go_led, value);
    end
    seen_go = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (go_led !== 1'b0) seen_go = 1'b1;
    end
    checks++;
    if (seen_go !== 1'b0) begin
      errors++;
      $display("FAIL false_start_go got go seen=%b want 0", seen_go);
    end
    gap();
    tap();
    checks++;
    if (show_error !== 1'b0 || value !== 14'(best_m)) begin
      errors++;
      $display("FAIL error_exit got err=%b value=%0d want 0 %0d", show_error, value, best_m);
    end
  endtask

  // Press pulse on the exact cycle the delay expires must win.
  task automatic test_press_at_zero();
    int d;
    logic seen_go;
    gap();
    arm(1'b0, d);
    repeat (d * T - 5) @(negedge clk);
    tap();
    checks++;
    if (show_error !== 1'b1 || go_led !== 1'b0) begin
      errors++;
      $display("FAIL press_at_zero got err=%b go=%b want 1 0", show_error, go_led);
    end
    seen_go = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (go_led !== 1'b0) seen_go = 1'b1;
    end
    checks++;
    if (seen_go !== 1'b0) begin
      errors++;
      $display("FAIL press_at_zero_go got go seen=%b want 0", seen_go);
    end
    gap();
    tap();
  endtask

  task automatic test_bounce_reset();
    int d, n;
    gap();
    arm(1'b1, d);
    wait_go(d, n);
    checks++;
    if (n != d * T || show_error !== 1'b0) begin
      errors++;
      $display("FAIL bounce_single got %0d cycles err=%b want %0d err=0", n, show_error, d * T);
    end
    repeat ($urandom_range(2, 100)) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (value !== 14'd0 || show_error !== 1'b0 || go_led !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_go got value=%0d err=%b go=%b want 0 0 0", value, show_error, go_led);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    best_m  = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (value !== 14'(best_m) || go_led !== 1'b0 || show_error !== 1'b0) begin
      errors++;
      $display("FAIL best_cleared got value=%0d go=%b err=%b want %0d 0 0", value, go_led, show_error, best_m);
    end
    gap();
    tap();
    gap();
    tap();
    checks++;
    if (show_error !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset got err=%b want 1", show_error);
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_rounds();
    test_zero_result();
    test_false_start();
    test_press_at_zero();
    test_bounce_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
